// File: rtl/snake_pkg.sv
// Shared Snake-game definitions: grid defaults, coordinate types, apple FSM states
// and the 16-bit Galois LFSR step used by the random blocks.
package snake_pkg;

   localparam int GRID_W_DEF = 32;
   localparam int GRID_H_DEF = 24;
   localparam int XW_DEF     = 5;
   localparam int YW_DEF     = 5;
   localparam int TRY_W      = 8;

   // Taps 16,14,13,11 for a right-shifting Galois register.
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef logic [XW_DEF-1:0] coord_x_t;
   typedef logic [YW_DEF-1:0] coord_y_t;

   typedef enum logic {
      ARMED  = 1'b0,
      SEARCH = 1'b1
   } apple_state_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module lfsr16_galois
   import snake_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   output logic [15:0] q_o
);

   localparam logic [15:0] RST_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] q_q;
   logic [15:0] q_d;

   always_comb begin
      q_d = lfsr_next(q_q);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/apple_spawner.sv
// Owns the apple: detects the head stepping onto it, pulses apple_colline once,
// then draws a new on-grid position from the LFSR with a deterministic fallback.
module apple_spawner
   import snake_pkg::*;
#(
   parameter int          GRID_W    = GRID_W_DEF,
   parameter int          GRID_H    = GRID_H_DEF,
   parameter int          XW        = XW_DEF,
   parameter int          YW        = YW_DEF,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          MAX_TRIES = 8,
   parameter int          INIT_X    = 20,
   parameter int          INIT_Y    = 12
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             game_en_i,
   // step_i is a single-cycle strobe with no back-pressure: head_x_i/head_y_i are
   // only meaningful while it is high, and a strobe is consumed only in ARMED.
   input  logic             step_i,
   input  logic [XW-1:0]    head_x_i,
   input  logic [YW-1:0]    head_y_i,
   output logic [XW-1:0]    apple_x_o,
   output logic [YW-1:0]    apple_y_o,
   output logic             apple_valid_o,
   output logic             apple_colline,
   output logic             dbg_state_o,
   output logic [TRY_W-1:0] dbg_try_cnt_o,
   output logic [15:0]      dbg_lfsr_o
);

   localparam logic [XW:0]      GW1      = (XW+1)'(GRID_W);
   localparam logic [YW:0]      GH1      = (YW+1)'(GRID_H);
   localparam logic [XW:0]      HALF_W   = (XW+1)'(GRID_W / 2);
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

   logic [15:0] lfsr;

   lfsr16_galois #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .q_o     (lfsr)
   );

   apple_state_e     state_q, state_d;
   logic [XW-1:0]    apple_x_q, apple_x_d;
   logic [YW-1:0]    apple_y_q, apple_y_d;
   logic [XW-1:0]    hx_q, hx_d;
   logic [YW-1:0]    hy_q, hy_d;
   logic             valid_q, valid_d;
   logic             coll_q, coll_d;
   logic [TRY_W-1:0] try_q, try_d;

   logic [XW-1:0] cand_x;
   logic [YW-1:0] cand_y;
   logic          cand_ok;
   logic          hit;
   logic [XW:0]   fb_sum;
   logic [XW-1:0] fb_x;

   assign cand_x  = lfsr[XW-1:0];
   assign cand_y  = lfsr[XW+YW-1:XW];
   assign cand_ok = ({1'b0, cand_x} < GW1) && ({1'b0, cand_y} < GH1)
                    && !((cand_x == hx_q) && (cand_y == hy_q));
   assign hit     = valid_q && (head_x_i == apple_x_q) && (head_y_i == apple_y_q);

   // Half-grid offset from the eaten spot, wrapped once; the extra bit keeps the carry.
   assign fb_sum = {1'b0, hx_q} + HALF_W;
   assign fb_x   = (fb_sum >= GW1) ? XW'(fb_sum - GW1) : fb_sum[XW-1:0];

   always_comb begin
      state_d   = state_q;
      apple_x_d = apple_x_q;
      apple_y_d = apple_y_q;
      hx_d      = hx_q;
      hy_d      = hy_q;
      valid_d   = valid_q;
      coll_d    = 1'b0;
      try_d     = try_q;
      if (game_en_i) begin
         case (state_q)
            ARMED: begin
               if (step_i && hit) begin
                  state_d = SEARCH;
                  coll_d  = 1'b1;
                  valid_d = 1'b0;
                  hx_d    = head_x_i;
                  hy_d    = head_y_i;
                  try_d   = '0;
               end
            end
            SEARCH: begin
               if (cand_ok) begin
                  apple_x_d = cand_x;
                  apple_y_d = cand_y;
                  valid_d   = 1'b1;
                  state_d   = ARMED;
               end else if (try_q == LAST_TRY) begin
                  apple_x_d = fb_x;
                  apple_y_d = hy_q;
                  valid_d   = 1'b1;
                  state_d   = ARMED;
               end else begin
                  try_d = try_q + 1'b1;
               end
            end
            default: state_d = ARMED;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= ARMED;
         apple_x_q <= XW'(INIT_X);
         apple_y_q <= YW'(INIT_Y);
         hx_q      <= '0;
         hy_q      <= '0;
         valid_q   <= 1'b1;
         coll_q    <= 1'b0;
         try_q     <= '0;
      end else begin
         state_q   <= state_d;
         apple_x_q <= apple_x_d;
         apple_y_q <= apple_y_d;
         hx_q      <= hx_d;
         hy_q      <= hy_d;
         valid_q   <= valid_d;
         coll_q    <= coll_d;
         try_q     <= try_d;
      end
   end

   assign apple_x_o     = apple_x_q;
   assign apple_y_o     = apple_y_q;
   assign apple_valid_o = valid_q;
   assign apple_colline = coll_q;
   assign dbg_state_o   = state_q;
   assign dbg_try_cnt_o = try_q;
   assign dbg_lfsr_o    = lfsr;

endmodule
